puf_key_sequencer: RTL and testbench

Top-level sequencer for the ring-oscillator PUF key extraction. On one `start` it walks `KEY_BITS` RO pairs. For each pair it selects the pair, lets the oscillators settle with the counters held in clear, runs both counters for a fixed window, then compares the counts into one key bit. It sits between the system controller and the RO-pair mux and counter datapath, and it replaces the single-measurement control FSM for multi-bit key generation.

---
 rtl/puf_key_sequencer.sv | 131 +++++++++++++
 tb/tb_puf_key_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_key_sequencer.sv
// Ring-oscillator PUF key sequencer: walks KEY_BITS RO pairs, settling, measuring
// and comparing each pair's counts into one key bit.
module puf_key_sequencer #(
  parameter int unsigned KEY_BITS = 16,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned WINDOW   = 10000,
  parameter int unsigned SETTLE   = 4,
  parameter int unsigned SEL_W    = $clog2(KEY_BITS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    cnt_a,
  input  logic [CNT_W-1:0]    cnt_b,
  output logic [SEL_W-1:0]    pair_sel,
  output logic                enable_ro,
  output logic                cnt_clear,
  output logic                cnt_en,
  output logic                busy,
  output logic                done,
  output logic [KEY_BITS-1:0] key,
  output logic                key_valid,
  output logic                tie_seen
);

  localparam int unsigned TMAX  = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int unsigned TMR_W = $clog2(TMAX + 1);

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW - 1);
  localparam logic [SEL_W-1:0] LAST_PAIR   = SEL_W'(KEY_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;

  // Control outputs are registered alongside the state, so each transition loads
  // the decode of the state being entered: {enable_ro, cnt_clear, cnt_en, busy, done}.
  function automatic logic [4:0] ctl(input state_t s);
    case (s)
      S_SETTLE:  return 5'b11010;
      S_MEASURE: return 5'b10110;
      S_COMPARE: return 5'b00010;
      S_DONE:    return 5'b00011;
      default:   return 5'b00000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      timer     <= '0;
      pair_sel  <= '0;
      key       <= '0;
      key_valid <= 1'b0;
      tie_seen  <= 1'b0;
      {enable_ro, cnt_clear, cnt_en, busy, done} <= '0;
    end else if (state != S_IDLE && abort) begin
      state     <= S_IDLE;
      timer     <= '0;
      key_valid <= 1'b0;
      {enable_ro, cnt_clear, cnt_en, busy, done} <= ctl(S_IDLE);
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state     <= S_SETTLE;
            timer     <= '0;
            pair_sel  <= '0;
            key       <= '0;
            key_valid <= 1'b0;
            tie_seen  <= 1'b0;
            {enable_ro, cnt_clear, cnt_en, busy, done} <= ctl(S_SETTLE);
          end
        end
        S_SETTLE: begin
          if (timer == SETTLE_LAST) begin
            state <= S_MEASURE;
            timer <= '0;
            {enable_ro, cnt_clear, cnt_en, busy, done} <= ctl(S_MEASURE);
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        S_MEASURE: begin
          if (timer == WINDOW_LAST) begin
            state <= S_COMPARE;
            timer <= '0;
            {enable_ro, cnt_clear, cnt_en, busy, done} <= ctl(S_COMPARE);
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        S_COMPARE: begin
          key[pair_sel] <= (cnt_a > cnt_b);
          if (cnt_a == cnt_b) begin
            tie_seen <= 1'b1;
          end
          if (pair_sel == LAST_PAIR) begin
            state     <= S_DONE;
            key_valid <= 1'b1;
            {enable_ro, cnt_clear, cnt_en, busy, done} <= ctl(S_DONE);
          end else begin
            state    <= S_SETTLE;
            timer    <= '0;
            pair_sel <= pair_sel + SEL_W'(1);
            {enable_ro, cnt_clear, cnt_en, busy, done} <= ctl(S_SETTLE);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          {enable_ro, cnt_clear, cnt_en, busy, done} <= ctl(S_IDLE);
        end
        default: begin
          state <= S_IDLE;
          timer <= '0;
          {enable_ro, cnt_clear, cnt_en, busy, done} <= ctl(S_IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_key_sequencer.sv
// Directed bench for puf_key_sequencer with KEY_BITS=4, WINDOW=8, SETTLE=2
// (11 cycles per bit, 45-cycle run, 46-cycle period with start held).
module tb_puf_key_sequencer;

  localparam int unsigned KB = 4;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;
  logic [1:0]    pair_sel;
  logic          enable_ro;
  logic          cnt_clear;
  logic          cnt_en;
  logic          busy;
  logic          done;
  logic [KB-1:0] key;
  logic          key_valid;
  logic          tie_seen;

  logic [CW-1:0] a_tab [KB];
  logic [CW-1:0] b_tab [KB];

  int n_cmp = 0;
  int n_bad = 0;

  puf_key_sequencer #(
    .KEY_BITS(KB),
    .CNT_W   (CW),
    .WINDOW  (8),
    .SETTLE  (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .cnt_a    (cnt_a),
    .cnt_b    (cnt_b),
    .pair_sel (pair_sel),
    .enable_ro(enable_ro),
    .cnt_clear(cnt_clear),
    .cnt_en   (cnt_en),
    .busy     (busy),
    .done     (done),
    .key      (key),
    .key_valid(key_valid),
    .tie_seen (tie_seen)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: counts presented for whichever pair is selected.
  assign cnt_a = a_tab[pair_sel];
  assign cnt_b = b_tab[pair_sel];

  wire [6:0]  obs = {pair_sel, enable_ro, cnt_clear, cnt_en, busy, done};
  wire [12:0] all_obs = {pair_sel, enable_ro, cnt_clear, cnt_en, busy, done, key, key_valid, tie_seen};

  // Expected {pair_sel, enable_ro, cnt_clear, cnt_en, busy, done} in cycle c (1..46) of a run.
  function automatic logic [6:0] exp_ctl(input int c);
    int k;
    int o;
    logic [1:0] p;
    if (c <= 44) begin
      k = (c - 1) / 11;
      o = (c - 1) % 11;
      p = k[1:0];
      if (o < 2)       return {p, 5'b11010};
      else if (o < 10) return {p, 5'b10110};
      else             return {p, 5'b00010};
    end else if (c == 45) begin
      return {2'd3, 5'b00011};
    end
    return {2'd3, 5'b00000};
  endfunction

  function automatic logic [6:0] exp_mask(input int c);
    return (c == 46) ? 7'h1F : 7'h7F;
  endfunction

  task automatic set_tabs(input logic [CW-1:0] a0, a1, a2, a3, b0, b1, b2, b3);
    a_tab[0] = a0; a_tab[1] = a1; a_tab[2] = a2; a_tab[3] = a3;
    b_tab[0] = b0; b_tab[1] = b1; b_tab[2] = b2; b_tab[3] = b3;
  endtask

  // Presents start for edge 0; returns #1 into cycle 1.
  task automatic launch(input bit hold);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    set_tabs(16'd9, 16'd9, 16'd9, 16'd9, 16'd1, 16'd1, 16'd1, 16'd1);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (all_obs !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_hold: got %b want %b", all_obs, 13'd0);
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (all_obs !== 13'd0) begin
        n_bad++;
        $display("FAIL idle_after_reset cyc %0d: got %b want %b", i, all_obs, 13'd0);
      end
    end
  endtask

  task automatic test_run;
    set_tabs(16'd200, 16'd100, 16'd300, 16'd50, 16'd100, 16'd150, 16'd200, 16'd60);
    launch(1'b0);
    for (int c = 1; c <= 46; c++) begin
      n_cmp++;
      if ((obs & exp_mask(c)) !== (exp_ctl(c) & exp_mask(c))) begin
        n_bad++;
        $display("FAIL run_ctl cyc %0d: got %b want %b", c, obs, exp_ctl(c));
      end
      if (c == 45) begin
        n_cmp++;
        if ({key, key_valid, tie_seen} !== {4'b0101, 1'b1, 1'b0}) begin
          n_bad++;
          $display("FAIL run_key: got %b want %b", {key, key_valid, tie_seen}, {4'b0101, 1'b1, 1'b0});
        end
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if ({key, key_valid, tie_seen} !== {4'b0101, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL run_key_hold: got %b want %b", {key, key_valid, tie_seen}, {4'b0101, 1'b1, 1'b0});
    end
  endtask

  task automatic test_tie;
    set_tabs(16'd5, 16'h0100, 16'd7, 16'd1, 16'd3, 16'h0100, 16'd9, 16'd0);
    launch(1'b0);
    for (int c = 1; c <= 46; c++) begin
      n_cmp++;
      if ((obs & exp_mask(c)) !== (exp_ctl(c) & exp_mask(c))) begin
        n_bad++;
        $display("FAIL tie_ctl cyc %0d: got %b want %b", c, obs, exp_ctl(c));
      end
      if (c == 22 || c == 23) begin
        n_cmp++;
        if (tie_seen !== (c == 23)) begin
          n_bad++;
          $display("FAIL tie_flag cyc %0d: got %b want %b", c, tie_seen, (c == 23));
        end
      end
      if (c == 45) begin
        n_cmp++;
        if ({key, key_valid, tie_seen} !== {4'b1001, 1'b1, 1'b1}) begin
          n_bad++;
          $display("FAIL tie_key: got %b want %b", {key, key_valid, tie_seen}, {4'b1001, 1'b1, 1'b1});
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_abort;
    set_tabs(16'd200, 16'd100, 16'd300, 16'd50, 16'd100, 16'd150, 16'd200, 16'd60);
    launch(1'b0);
    for (int c = 1; c <= 27; c++) begin
      n_cmp++;
      if (obs !== exp_ctl(c)) begin
        n_bad++;
        $display("FAIL abort_pre cyc %0d: got %b want %b", c, obs, exp_ctl(c));
      end
      if (c == 27) abort = 1'b1;
      @(posedge clk);
      #1;
    end
    abort = 1'b0;
    n_cmp++;
    if ({obs[4:0], key, key_valid} !== {5'b00000, 4'b0001, 1'b0}) begin
      n_bad++;
      $display("FAIL abort_idle: got %b want %b", {obs[4:0], key, key_valid}, {5'b00000, 4'b0001, 1'b0});
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, done, key_valid} !== 3'b000) begin
        n_bad++;
        $display("FAIL abort_quiet cyc %0d: got %b want %b", i, {busy, done, key_valid}, 3'b000);
      end
    end
    launch(1'b0);
    for (int c = 1; c <= 46; c++) begin
      n_cmp++;
      if ((obs & exp_mask(c)) !== (exp_ctl(c) & exp_mask(c))) begin
        n_bad++;
        $display("FAIL abort_rerun cyc %0d: got %b want %b", c, obs, exp_ctl(c));
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if ({key, key_valid} !== {4'b0101, 1'b1}) begin
      n_bad++;
      $display("FAIL abort_rerun_key: got %b want %b", {key, key_valid}, {4'b0101, 1'b1});
    end
  endtask

  task automatic test_back_to_back;
    int cc;
    set_tabs(16'd200, 16'd100, 16'd300, 16'd50, 16'd100, 16'd150, 16'd200, 16'd60);
    launch(1'b1);
    for (int c = 1; c <= 92; c++) begin
      cc = ((c - 1) % 46) + 1;
      n_cmp++;
      if ((obs & exp_mask(cc)) !== (exp_ctl(cc) & exp_mask(cc))) begin
        n_bad++;
        $display("FAIL b2b_ctl cyc %0d: got %b want %b", c, obs, exp_ctl(cc));
      end
      if (c == 45) begin
        n_cmp++;
        if ({key, key_valid} !== {4'b0101, 1'b1}) begin
          n_bad++;
          $display("FAIL b2b_key1: got %b want %b", {key, key_valid}, {4'b0101, 1'b1});
        end
      end
      if (c == 46) set_tabs(16'd9, 16'd9, 16'd9, 16'd9, 16'd1, 16'd1, 16'd1, 16'd1);
      if (c == 47) begin
        n_cmp++;
        if ({key, key_valid} !== {4'b0000, 1'b0}) begin
          n_bad++;
          $display("FAIL b2b_clear: got %b want %b", {key, key_valid}, {4'b0000, 1'b0});
        end
      end
      if (c == 91) begin
        n_cmp++;
        if ({key, key_valid, tie_seen} !== {4'b1111, 1'b1, 1'b0}) begin
          n_bad++;
          $display("FAIL b2b_key2: got %b want %b", {key, key_valid, tie_seen}, {4'b1111, 1'b1, 1'b0});
        end
      end
      if (c == 92) start = 1'b0;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL b2b_stop: got %b want %b", {busy, done}, 2'b00);
    end
  endtask

  task automatic test_reset_mid;
    set_tabs(16'd200, 16'd100, 16'd300, 16'd50, 16'd100, 16'd150, 16'd200, 16'd60);
    launch(1'b0);
    for (int c = 1; c <= 43; c++) begin
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (obs !== exp_ctl(44)) begin
      n_bad++;
      $display("FAIL midrst_compare: got %b want %b", obs, exp_ctl(44));
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (all_obs !== 13'd0) begin
      n_bad++;
      $display("FAIL midrst_zero: got %b want %b", all_obs, 13'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (all_obs !== 13'd0) begin
        n_bad++;
        $display("FAIL start_abort_idle cyc %0d: got %b want %b", i, all_obs, 13'd0);
      end
      @(posedge clk);
      #1;
    end
    launch(1'b0);
    for (int c = 1; c <= 46; c++) begin
      n_cmp++;
      if ((obs & exp_mask(c)) !== (exp_ctl(c) & exp_mask(c))) begin
        n_bad++;
        $display("FAIL post_rst_run cyc %0d: got %b want %b", c, obs, exp_ctl(c));
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if ({key, key_valid, tie_seen} !== {4'b0101, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL post_rst_key: got %b want %b", {key, key_valid, tie_seen}, {4'b0101, 1'b1, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_tie();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
